// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and elaboration-time helpers for the
// multiplexed 7-segment display controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_BLANK  = 2'b10,
        MODE_TEST   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ALL   = 7'h00;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int BCD_W          = 4 * DEF_NUM_DIGITS;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

    function automatic longint pow10(input int k);
        longint r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Host-side bundle of the display controller: value/load handshake, display
// controls and the board-facing segment and anode pins.
interface seg7_display_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14
);
    logic [VALUE_W-1:0]    value;
    logic                  load;
    logic [1:0]            mode;
    logic                  lz_suppress;
    logic                  busy;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output value, load, mode, lz_suppress,
        input  busy, seg, an
    );

    modport slave (
        input  value, load, mode, lz_suppress,
        output busy, seg, an
    );
endinterface

// File: rtl/seg7_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3-then-shift step per cycle,
// followed by a single done cycle; overflow is judged on the captured value.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [VALUE_W-1:0]        i_value,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [4*NUM_DIGITS-1:0]   o_bcd,
    output logic                      o_ovf
);
    localparam int          BCD_BITS = bcd_width(NUM_DIGITS);
    localparam int          ITER_W   = clog2(VALUE_W);
    localparam logic [63:0] MAX_VAL  = 64'(pow10(NUM_DIGITS) - 1);

    conv_state_e         r_state;
    conv_state_e         w_state_next;
    logic [VALUE_W-1:0]  r_bin;
    logic [VALUE_W-1:0]  w_bin_next;
    logic [BCD_BITS-1:0] r_bcd;
    logic [BCD_BITS-1:0] w_bcd_next;
    logic [BCD_BITS-1:0] w_bcd_adj;
    logic [ITER_W-1:0]   r_iter;
    logic [ITER_W-1:0]   w_iter_next;
    logic                r_ovf;
    logic                w_ovf_next;
    logic                r_busy;

    // Digits of 5 or more get +3 so the following shift carries into the next decade.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                      r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
    end

    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_bcd_next   = r_bcd;
        w_iter_next  = r_iter;
        w_ovf_next   = r_ovf;
        case (r_state)
            CONV_IDLE: begin
                if (i_start) begin
                    w_state_next = CONV_SHIFT;
                    w_bin_next   = i_value;
                    w_bcd_next   = '0;
                    w_iter_next  = '0;
                    w_ovf_next   = (64'(i_value) > MAX_VAL);
                end
            end
            CONV_SHIFT: begin
                w_bcd_next  = {w_bcd_adj[BCD_BITS-2:0], r_bin[VALUE_W-1]};
                w_bin_next  = {r_bin[VALUE_W-2:0], 1'b0};
                w_iter_next = r_iter + ITER_W'(1);
                if (r_iter == ITER_W'(VALUE_W - 1)) begin
                    w_state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                w_state_next = CONV_IDLE;
            end
            default: begin
                w_state_next = CONV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CONV_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_bcd   <= w_bcd_next;
            r_iter  <= w_iter_next;
            r_ovf   <= w_ovf_next;
            r_busy  <= (w_state_next != CONV_IDLE);
        end
    end

    assign o_busy = r_busy;
    assign o_done = (r_state == CONV_DONE);
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multiplexed N-digit active-low 7-segment controller: refresh/blink tick
// counters, committed BCD display register and a registered segment/anode mux.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 500,
    parameter int BLINK_HZ   = 2
) (
    input  logic              clk,
    input  logic              rst,
    seg7_display_ctrl_if.slave bus
);
    localparam int REF_DIV   = CLK_HZ / REFRESH_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int REF_W     = clog2(REF_DIV);
    localparam int BLINK_W   = clog2(BLINK_DIV);
    localparam int SCAN_W    = clog2(NUM_DIGITS);
    localparam int BCD_BITS  = bcd_width(NUM_DIGITS);

    logic [REF_W-1:0]      r_ref_cnt;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic [SCAN_W-1:0]     r_scan;
    logic                  r_phase;
    logic [BCD_BITS-1:0]   r_disp;
    logic                  r_ovf;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_ref_tick;
    logic                  w_blink_tick;
    logic                  w_conv_busy;
    logic                  w_conv_done;
    logic [BCD_BITS-1:0]   w_conv_bcd;
    logic                  w_conv_ovf;
    logic [3:0]            w_digit   [NUM_DIGITS];
    logic [6:0]            w_pat     [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_nonzero;
    logic [NUM_DIGITS-1:0] w_vis;
    logic [6:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (bus.load),
        .i_value (bus.value),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd),
        .o_ovf   (w_conv_ovf)
    );

    assign w_ref_tick   = (r_ref_cnt == REF_W'(REF_DIV - 1));
    assign w_blink_tick = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt   <= '0;
            r_blink_cnt <= '0;
            r_scan      <= '0;
            r_phase     <= 1'b1;
        end else begin
            r_ref_cnt   <= w_ref_tick ? '0 : r_ref_cnt + REF_W'(1);
            r_blink_cnt <= w_blink_tick ? '0 : r_blink_cnt + BLINK_W'(1);
            if (w_blink_tick) begin
                r_phase <= ~r_phase;
            end
            if (w_ref_tick) begin
                r_scan <= (r_scan == SCAN_W'(NUM_DIGITS - 1)) ? '0 : r_scan + SCAN_W'(1);
            end
        end
    end

    // Digits and overflow flag change together, so scanning never shows a mix.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_conv_done) begin
            r_disp <= w_conv_bcd;
            r_ovf  <= w_conv_ovf;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digit[gi]   = r_disp[4*gi +: 4];
        assign w_nonzero[gi] = |w_digit[gi];
        if (gi == 0) begin : g_lsd
            assign w_vis[gi] = 1'b1;
        end else begin : g_upper
            assign w_vis[gi] = |w_nonzero[NUM_DIGITS-1:gi];
        end
        assign w_pat[gi] = r_ovf                             ? SEG_DASH  :
                           (bus.lz_suppress && !w_vis[gi])   ? SEG_BLANK :
                           seg_decode(w_digit[gi]);
    end

    always_comb begin
        w_seg_next = w_pat[r_scan];
        w_an_next  = ~(NUM_DIGITS'(1) << r_scan);
        case (mode_e'(bus.mode))
            MODE_BLANK: w_an_next = '1;
            MODE_BLINK: begin
                if (!r_phase) begin
                    w_an_next = '1;
                end
            end
            MODE_TEST:  w_seg_next = SEG_ALL;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.busy = w_conv_busy;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed plus randomized stimulus for seg7_display_ctrl, compared every
// cycle against a decimal-arithmetic reference model of the display.
module tb_seg7_display_ctrl;
    localparam int N      = 4;
    localparam int VW     = 14;
    localparam int CLK_HZ = 1000;
    localparam int REF_HZ = 100;
    localparam int BLK_HZ = 5;
    localparam int REF    = CLK_HZ / REF_HZ;
    localparam int BLK    = CLK_HZ / (2 * BLK_HZ);
    localparam int MAXV   = 9999;

    localparam logic [1:0] M_NORMAL = 2'b00;
    localparam logic [1:0] M_BLINK  = 2'b01;
    localparam logic [1:0] M_BLANK  = 2'b10;
    localparam logic [1:0] M_TEST   = 2'b11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg7_display_ctrl_if #(.NUM_DIGITS(N), .VALUE_W(VW)) bus ();

    seg7_display_ctrl #(
        .NUM_DIGITS (N),
        .VALUE_W    (VW),
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REF_HZ),
        .BLINK_HZ   (BLK_HZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Active-high gfedcba patterns for 0-9; the pins are the inverse.
    logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_edges   = 0;
    int m_cyc     = 0;
    bit m_active  = 1'b0;
    int m_load_at = 0;
    int m_pend    = 0;
    bit m_pend_ov = 1'b0;
    int m_disp    = 0;
    bit m_disp_ov = 1'b0;
    bit m_busy    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int p10(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    // One clock: predict pins from pre-edge model state, clock, compare, advance model.
    task automatic tick();
        int         scan;
        int         d;
        bit         phase;
        bit         busy_before;
        bit         seg_ck;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        if (rst) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            seg_ck  = 1'b1;
        end else begin
            scan  = (m_edges / REF) % N;
            phase = ((m_edges / BLK) % 2) == 0;
            d     = (m_disp / p10(scan)) % 10;
            if (m_disp_ov)
                exp_seg = 7'h3F;
            else if (bus.lz_suppress && scan != 0 && m_disp < p10(scan))
                exp_seg = 7'h7F;
            else
                exp_seg = ~seg_hi[d];
            exp_an = ~(4'b0001 << scan);
            if (bus.mode == M_BLANK || (bus.mode == M_BLINK && !phase)) exp_an = 4'hF;
            if (bus.mode == M_TEST) exp_seg = 7'h00;
            seg_ck = (exp_an != 4'hF);
        end

        if (rst) begin
            m_active  = 1'b0;
            m_disp    = 0;
            m_disp_ov = 1'b0;
            m_edges   = 0;
            m_busy    = 1'b0;
        end else begin
            busy_before = m_busy;
            if (m_active && m_cyc == m_load_at + VW + 1) begin
                m_disp    = m_pend;
                m_disp_ov = m_pend_ov;
                m_active  = 1'b0;
            end
            if (bus.load && !busy_before) begin
                m_active  = 1'b1;
                m_load_at = m_cyc;
                m_pend    = int'(bus.value);
                m_pend_ov = int'(bus.value) > MAXV;
            end
            m_busy  = m_active && (m_cyc - m_load_at <= VW);
            m_edges = m_edges + 1;
        end
        m_cyc = m_cyc + 1;

        @(posedge clk);
        #1;
        check("an", 32'(bus.an), 32'(exp_an));
        if (seg_ck) check("seg", 32'(bus.seg), 32'(exp_seg));
        check("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int v);
        bus.value = VW'(v);
        bus.load  = 1'b1;
        $display("load value=%0d mode=%0d lz=%0d t=%0t", v, bus.mode, bus.lz_suppress, $time);
        tick();
        bus.load  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.value       = '0;
        bus.load        = 1'b0;
        bus.mode        = M_NORMAL;
        bus.lz_suppress = 1'b0;

        run(3);
        rst = 1'b0;
        run(45);

        do_load(1234);  run(45);
        do_load(10000); run(40);
        do_load(9999);  run(45);

        bus.lz_suppress = 1'b1;
        do_load(7);     run(45);
        bus.lz_suppress = 1'b0;
        run(40);
        bus.lz_suppress = 1'b1;
        do_load(0);     run(45);
        bus.lz_suppress = 1'b0;

        do_load(42);    run(2);
        do_load(99);    run(45);

        do_load(55);    run(4);
        rst = 1'b1;     run(1);
        rst = 1'b0;     run(45);

        // Load held high: accepted again on the first cycle after busy falls.
        bus.value = VW'(321);
        bus.load  = 1'b1;
        run(20);
        bus.load  = 1'b0;
        run(30);

        bus.mode = M_BLINK; run(420);
        bus.mode = M_BLANK; run(50);
        bus.mode = M_TEST;  run(50);
        bus.mode = M_NORMAL;

        for (int i = 0; i < 3000; i++) begin
            bus.load = ($urandom_range(0, 9) == 0);
            if (bus.load)
                bus.value = ($urandom_range(0, 3) == 0) ? VW'($urandom_range(9990, 16383))
                                                        : VW'($urandom_range(0, 9999));
            if ($urandom_range(0, 63) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.lz_suppress = ~bus.lz_suppress;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
